alu_bist_ctrl: RTL and testbench

Built-in self-test controller that drives the registered ALU harness (input registers → ALU → output register) and reads its result back.
- Generates pseudo-random operand pairs and ALU control codes from LFSRs.
- Aligns each issued vector with the harness pipeline latency.
- Compresses every returned result into a MISR signature, then compares it against a golden value.
- Used for at-speed testing and frequency characterisation of the ALU without external pattern storage.

---
 rtl/alu_bist_pkg.sv | 17 +
 rtl/lfsr_galois.sv | 38 +++
 rtl/alu_bist_ctrl.sv | 147 ++++++++++++++
 tb/tb_alu_bist_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_bist_pkg.sv
// rtl/alu_bist_pkg.sv - shared types and constants for the ALU BIST controller
package alu_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

  // x^32 + x^22 + x^2 + x + 1, shared by the operand LFSRs and the MISR
  localparam logic [31:0] LFSR_MASK      = 32'h80200003;
  localparam logic [31:0] DEFAULT_SEED_A = 32'h0000_0001;
  localparam logic [31:0] DEFAULT_SEED_B = 32'h0000_ACE1;
  localparam logic [31:0] DEFAULT_SEED_C = 32'h0000_0005;

endpackage

// File: rtl/lfsr_galois.sv
// rtl/lfsr_galois.sv - right-shifting Galois LFSR with seed load and step enable
module lfsr_galois
  import alu_bist_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] MASK  = LFSR_MASK[WIDTH-1:0],
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] state_q, state_d;

  // load wins over en so a restart always begins from the seed
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = SEED;
    end else if (en) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? MASK : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule

// File: rtl/alu_bist_ctrl.sv
// rtl/alu_bist_ctrl.sv - BIST controller: LFSR vector generation, latency alignment, MISR compare
module alu_bist_ctrl
  import alu_bist_pkg::*;
#(
  parameter int          N           = 32,
  parameter int          CTRL_W      = 4,
  parameter int          NUM_OPS     = 10,
  parameter int          NUM_VECTORS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] SEED_A      = DEFAULT_SEED_A,
  parameter logic [31:0] SEED_B      = DEFAULT_SEED_B,
  parameter logic [31:0] SEED_C      = DEFAULT_SEED_C
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [N-1:0]      a_o,
  output logic [N-1:0]      b_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  input  logic [N-1:0]      y_i,
  input  logic [N-1:0]      expected_sig,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N-1:0]      signature,
  output logic [15:0]       vec_count
);

  localparam logic [CTRL_W-1:0] NUM_OPS_C = CTRL_W'(NUM_OPS);
  localparam logic [15:0]       LAST_VEC  = 16'(NUM_VECTORS - 1);

  bist_state_e       state_q, state_d;
  logic [N-1:0]      a_q, a_d, b_q, b_d, sig_q, sig_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [15:0]       vc_q, vc_d;
  logic [LATENCY:0]  vld_q, vld_d;
  logic              pass_q, pass_d;

  logic [31:0]       lfsr_a_q, lfsr_b_q, lfsr_c_q;
  logic              lfsr_load, issue;
  logic [CTRL_W-1:0] ctrl_raw, ctrl_mod;
  logic [N-1:0]      misr_step;
  logic              tag_out, last_tag;
  logic              unused_lfsr_bits;

  assign lfsr_load = start && ((state_q == IDLE) || (state_q == DONE));
  assign issue     = (state_q == RUN);

  lfsr_galois #(.WIDTH(32), .MASK(LFSR_MASK), .SEED(SEED_A)) u_lfsr_a (
    .clk(clk), .reset(reset), .load(lfsr_load), .en(issue), .q(lfsr_a_q)
  );
  lfsr_galois #(.WIDTH(32), .MASK(LFSR_MASK), .SEED(SEED_B)) u_lfsr_b (
    .clk(clk), .reset(reset), .load(lfsr_load), .en(issue), .q(lfsr_b_q)
  );
  lfsr_galois #(.WIDTH(32), .MASK(LFSR_MASK), .SEED(SEED_C)) u_lfsr_c (
    .clk(clk), .reset(reset), .load(lfsr_load), .en(issue), .q(lfsr_c_q)
  );

  assign unused_lfsr_bits = ^{lfsr_a_q, lfsr_b_q, lfsr_c_q};

  // one conditional subtract folds the raw code into 0..NUM_OPS-1
  assign ctrl_raw = lfsr_c_q[CTRL_W-1:0];
  assign ctrl_mod = (ctrl_raw >= NUM_OPS_C) ? (ctrl_raw - NUM_OPS_C) : ctrl_raw;

  assign misr_step = {sig_q[N-2:0], 1'b0} ^ (sig_q[N-1] ? LFSR_MASK[N-1:0] : '0) ^ y_i;

  // the tag in the top slot marks the edge at which y_i carries that vector's result
  assign tag_out  = vld_q[LATENCY];
  assign last_tag = tag_out && (vld_q[LATENCY-1:0] == '0);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    sig_d   = sig_q;
    vc_d    = vc_q;
    pass_d  = pass_q;
    vld_d   = {vld_q[LATENCY-1:0], issue};
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          sig_d   = '0;
          vc_d    = '0;
          vld_d   = '0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        a_d    = lfsr_a_q[N-1:0];
        b_d    = lfsr_b_q[N-1:0];
        ctrl_d = ctrl_mod;
        vc_d   = vc_q + 16'd1;
        if (tag_out) begin
          sig_d = misr_step;
        end
        if (vc_q == LAST_VEC) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tag_out) begin
          sig_d = misr_step;
        end
        // compare against the signature being written on this same edge
        if (last_tag) begin
          state_d = DONE;
          pass_d  = (misr_step == expected_sig);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      sig_q   <= '0;
      vc_q    <= '0;
      vld_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      sig_q   <= sig_d;
      vc_q    <= vc_d;
      vld_q   <= vld_d;
      pass_q  <= pass_d;
    end
  end

  assign a_o        = a_q;
  assign b_o        = b_q;
  assign alu_ctrl_o = ctrl_q;
  assign signature  = sig_q;
  assign vec_count  = vc_q;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// tb/tb_alu_bist_ctrl.sv - directed self-checking bench for alu_bist_ctrl
module tb_alu_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rst_n   = 4'b0000;
  logic [3:0]  start_r = 4'b0000;
  logic [31:0] exp_sig [4];
  logic [31:0] zero_y  = 32'h0;
  logic [31:0] a_w [4];
  logic [31:0] b_w [4];
  logic [31:0] sig_w [4];
  logic [3:0]  ctrl_w [4];
  logic [15:0] vc_w [4];
  logic [3:0]  busy_w, done_w, pass_w;
  logic [31:0] echo_d1 = 32'h0, echo_d2 = 32'h0;

  int checks   = 0;
  int failures = 0;

  // instance 0: pipeline, 1: default operand stream, 2: echo signature, 3: latency 1
  alu_bist_ctrl #(.NUM_VECTORS(4), .LATENCY(2)) dut0 (
    .clk(clk), .reset(rst_n[0]), .start(start_r[0]), .a_o(a_w[0]), .b_o(b_w[0]),
    .alu_ctrl_o(ctrl_w[0]), .y_i(zero_y), .expected_sig(exp_sig[0]), .busy(busy_w[0]),
    .done(done_w[0]), .pass(pass_w[0]), .signature(sig_w[0]), .vec_count(vc_w[0])
  );
  alu_bist_ctrl dut1 (
    .clk(clk), .reset(rst_n[1]), .start(start_r[1]), .a_o(a_w[1]), .b_o(b_w[1]),
    .alu_ctrl_o(ctrl_w[1]), .y_i(zero_y), .expected_sig(exp_sig[1]), .busy(busy_w[1]),
    .done(done_w[1]), .pass(pass_w[1]), .signature(sig_w[1]), .vec_count(vc_w[1])
  );
  alu_bist_ctrl #(.NUM_VECTORS(3), .LATENCY(2)) dut2 (
    .clk(clk), .reset(rst_n[2]), .start(start_r[2]), .a_o(a_w[2]), .b_o(b_w[2]),
    .alu_ctrl_o(ctrl_w[2]), .y_i(echo_d2), .expected_sig(exp_sig[2]), .busy(busy_w[2]),
    .done(done_w[2]), .pass(pass_w[2]), .signature(sig_w[2]), .vec_count(vc_w[2])
  );
  alu_bist_ctrl #(.NUM_VECTORS(4), .LATENCY(1)) dut3 (
    .clk(clk), .reset(rst_n[3]), .start(start_r[3]), .a_o(a_w[3]), .b_o(b_w[3]),
    .alu_ctrl_o(ctrl_w[3]), .y_i(zero_y), .expected_sig(exp_sig[3]), .busy(busy_w[3]),
    .done(done_w[3]), .pass(pass_w[3]), .signature(sig_w[3]), .vec_count(vc_w[3])
  );

  // two-stage harness model: y_i follows a_o by two registers
  always @(posedge clk) begin
    echo_d1 <= a_w[2];
    echo_d2 <= echo_d1;
  end

  typedef struct {
    int          inst;
    int          edge_n;
    logic        busy;
    logic        done;
    logic [15:0] vc;
  } pipe_vec_t;

  pipe_vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int i);
    start_r[i] = 1'b1;
    tick();
    start_r[i] = 1'b0;
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [3:0] ctrl_map(input logic [31:0] s);
    logic [3:0] c;
    c = s[3:0];
    return (c >= 4'd10) ? c - 4'd10 : c;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ma, mb, mc;
    int cur;

    for (int i = 0; i < 4; i++) exp_sig[i] = 32'h0;

    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_a%0d", i), a_w[i], 32'h0);
      chk($sformatf("reset_ctrl%0d", i), {28'h0, ctrl_w[i]}, 32'h0);
      chk($sformatf("reset_sig%0d", i), sig_w[i], 32'h0);
      chk($sformatf("reset_vc%0d", i), {16'h0, vc_w[i]}, 32'h0);
      chk($sformatf("reset_flags%0d", i), {29'h0, busy_w[i], done_w[i], pass_w[i]}, 32'h0);
    end
    rst_n = 4'b1111;
    tick();

    // pipeline length, LATENCY=2 and LATENCY=1
    tbl.push_back('{0, 1, 1'b1, 1'b0, 16'd1});
    tbl.push_back('{0, 2, 1'b1, 1'b0, 16'd2});
    tbl.push_back('{0, 3, 1'b1, 1'b0, 16'd3});
    tbl.push_back('{0, 4, 1'b1, 1'b0, 16'd4});
    tbl.push_back('{0, 5, 1'b1, 1'b0, 16'd4});
    tbl.push_back('{0, 6, 1'b1, 1'b0, 16'd4});
    tbl.push_back('{0, 7, 1'b0, 1'b1, 16'd4});
    tbl.push_back('{0, 8, 1'b0, 1'b1, 16'd4});
    tbl.push_back('{3, 1, 1'b1, 1'b0, 16'd1});
    tbl.push_back('{3, 3, 1'b1, 1'b0, 16'd3});
    tbl.push_back('{3, 4, 1'b1, 1'b0, 16'd4});
    tbl.push_back('{3, 5, 1'b1, 1'b0, 16'd4});
    tbl.push_back('{3, 6, 1'b0, 1'b1, 16'd4});
    tbl.push_back('{3, 7, 1'b0, 1'b1, 16'd4});

    cur = 0;
    foreach (tbl[j]) begin
      if (tbl[j].edge_n == 1) begin
        pulse_start(tbl[j].inst);
        cur = 0;
      end
      while (cur < tbl[j].edge_n) begin
        tick();
        cur++;
      end
      chk($sformatf("pipe_i%0d_e%0d_busy", tbl[j].inst, cur), {31'h0, busy_w[tbl[j].inst]}, {31'h0, tbl[j].busy});
      chk($sformatf("pipe_i%0d_e%0d_done", tbl[j].inst, cur), {31'h0, done_w[tbl[j].inst]}, {31'h0, tbl[j].done});
      chk($sformatf("pipe_i%0d_e%0d_vc", tbl[j].inst, cur), {16'h0, vc_w[tbl[j].inst]}, {16'h0, tbl[j].vc});
    end
    chk("pipe0_sig", sig_w[0], 32'h0);
    chk("pipe0_pass", {31'h0, pass_w[0]}, 32'h1);
    chk("pipe3_sig", sig_w[3], 32'h0);
    chk("pipe3_pass", {31'h0, pass_w[3]}, 32'h1);

    // operand and control stream with default seeds
    pulse_start(1);
    tick();
    chk("seq_e1_a", a_w[1], 32'h0000_0001);
    chk("seq_e1_b", b_w[1], 32'h0000_ACE1);
    chk("seq_e1_ctrl", {28'h0, ctrl_w[1]}, 32'd5);
    tick();
    chk("seq_e2_a", a_w[1], 32'h8020_0003);
    chk("seq_e2_b", b_w[1], 32'h8020_5673);
    chk("seq_e2_ctrl", {28'h0, ctrl_w[1]}, 32'd1);
    ma = 32'h8020_0003;
    mb = 32'h8020_5673;
    mc = 32'h8020_0001;
    for (int k = 3; k < 40; k++) begin
      tick();
      ma = lfsr_next(ma);
      mb = lfsr_next(mb);
      mc = lfsr_next(mc);
      chk($sformatf("seq_e%0d_a", k), a_w[1], ma);
      chk($sformatf("seq_e%0d_b", k), b_w[1], mb);
      chk($sformatf("seq_e%0d_ctrl", k), {28'h0, ctrl_w[1]}, {28'h0, ctrl_map(mc)});
      chk($sformatf("seq_e%0d_ctrl_range", k), {31'h0, ctrl_w[1] < 4'd10}, 32'h1);
      chk($sformatf("seq_e%0d_vc", k), {16'h0, vc_w[1]}, k);
    end

    // signature over echoed operands {1, 80200003, c0300002}
    exp_sig[2] = 32'h4050_0003;
    pulse_start(2);
    repeat (5) tick();
    chk("sig_e5_done", {31'h0, done_w[2]}, 32'h0);
    tick();
    chk("sig_e6_done", {31'h0, done_w[2]}, 32'h1);
    chk("sig_e6_busy", {31'h0, busy_w[2]}, 32'h0);
    chk("sig_e6_value", sig_w[2], 32'h4050_0003);
    chk("sig_e6_pass", {31'h0, pass_w[2]}, 32'h1);

    exp_sig[2] = 32'h4050_0002;
    pulse_start(2);
    chk("restart_done_clr", {31'h0, done_w[2]}, 32'h0);
    chk("restart_pass_clr", {31'h0, pass_w[2]}, 32'h0);
    chk("restart_sig_clr", sig_w[2], 32'h0);
    chk("restart_vc_clr", {16'h0, vc_w[2]}, 32'h0);
    repeat (6) tick();
    chk("badsig_value", sig_w[2], 32'h4050_0003);
    chk("badsig_done", {31'h0, done_w[2]}, 32'h1);
    chk("badsig_pass", {31'h0, pass_w[2]}, 32'h0);

    // reset at edge 3 of a run, then a clean rerun
    exp_sig[2] = 32'h4050_0003;
    pulse_start(2);
    tick();
    tick();
    rst_n[2] = 1'b0;
    tick();
    chk("rst_a", a_w[2], 32'h0);
    chk("rst_b", b_w[2], 32'h0);
    chk("rst_ctrl", {28'h0, ctrl_w[2]}, 32'h0);
    chk("rst_sig", sig_w[2], 32'h0);
    chk("rst_vc", {16'h0, vc_w[2]}, 32'h0);
    chk("rst_flags", {29'h0, busy_w[2], done_w[2], pass_w[2]}, 32'h0);
    rst_n[2] = 1'b1;
    tick();
    chk("rst_idle_busy", {31'h0, busy_w[2]}, 32'h0);
    pulse_start(2);
    tick();
    chk("rerun_a", a_w[2], 32'h0000_0001);
    chk("rerun_b", b_w[2], 32'h0000_ACE1);
    chk("rerun_ctrl", {28'h0, ctrl_w[2]}, 32'd5);
    repeat (5) tick();
    chk("rerun_sig", sig_w[2], 32'h4050_0003);
    chk("rerun_done", {31'h0, done_w[2]}, 32'h1);
    chk("rerun_pass", {31'h0, pass_w[2]}, 32'h1);

    // extra starts during RUN (edge 2) and DRAIN (edge 5) are ignored
    pulse_start(0);
    chk("busy_start_done_clr", {31'h0, done_w[0]}, 32'h0);
    chk("busy_start_vc_clr", {16'h0, vc_w[0]}, 32'h0);
    for (int e = 1; e <= 9; e++) begin
      start_r[0] = (e == 2) || (e == 5);
      tick();
      start_r[0] = 1'b0;
      chk($sformatf("busy_start_e%0d_vc", e), {16'h0, vc_w[0]}, (e < 4) ? e : 4);
      chk($sformatf("busy_start_e%0d_done", e), {31'h0, done_w[0]}, {31'h0, e >= 7});
      chk($sformatf("busy_start_e%0d_busy", e), {31'h0, busy_w[0]}, {31'h0, e < 7});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
